// File: rtl/control_unit_mc.sv
// rtl/control_unit_mc.sv - multi-cycle processor control FSM with wait states, stall, HALT/TRAP and retired counter
module control_unit_mc #(
  parameter int                 CODE_W     = 3,
  parameter logic [CODE_W-1:0]  STORE_CODE = {CODE_W{1'b1}},
  parameter logic [CODE_W-1:0]  HALT_CODE  = '0,
  parameter int                 ROM_WAIT   = 0,
  parameter int                 RAM_WAIT   = 0,
  parameter int                 RET_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        instruction_type,
  input  logic [CODE_W-1:0] instruction_code,
  input  logic              stall,
  input  logic              resume,
  output logic [2:0]        state,
  output logic              ma,
  output logic              rd,
  output logic              wd,
  output logic              rw,
  output logic              enram,
  output logic              enrom,
  output logic              fsr_sel,
  output logic              ir_load,
  output logic              alu_en,
  output logic              pc_inc,
  output logic              halted,
  output logic              trap,
  output logic [RET_W-1:0]  retired
);

  localparam logic [2:0] FETCH     = 3'b000;
  localparam logic [2:0] DECODE    = 3'b001;
  localparam logic [2:0] READMEM   = 3'b010;
  localparam logic [2:0] WRITEMEM  = 3'b011;
  localparam logic [2:0] EXECALU   = 3'b100;
  localparam logic [2:0] STOREEXEC = 3'b101;
  localparam logic [2:0] HALT      = 3'b110;
  localparam logic [2:0] TRAP      = 3'b111;

  localparam logic [3:0] ROM_LAST = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_LAST = 4'(RAM_WAIT);

  logic [3:0] cnt;
  logic       fsr_q;
  logic [2:0] state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:     if (cnt == ROM_LAST) state_nx = DECODE;
      DECODE: begin
        case (instruction_type)
          2'b00:        state_nx = EXECALU;
          2'b01, 2'b10: state_nx = (instruction_code == STORE_CODE) ? WRITEMEM : READMEM;
          default:      state_nx = (instruction_code == HALT_CODE) ? HALT : TRAP;
        endcase
      end
      READMEM:   if (cnt == RAM_LAST) state_nx = EXECALU;
      WRITEMEM:  if (cnt == RAM_LAST) state_nx = STOREEXEC;
      EXECALU:   state_nx = FETCH;
      STOREEXEC: state_nx = FETCH;
      HALT:      if (resume) state_nx = FETCH;
      default:   state_nx = FETCH;
    endcase
  end

  // HALT keeps cnt at 0 so a long halt cannot wrap the wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      cnt     <= 4'd0;
      fsr_q   <= 1'b0;
      retired <= '0;
    end else if (!stall) begin
      state <= state_nx;
      cnt   <= (state_nx != state || state == HALT) ? 4'd0 : cnt + 4'd1;
      if (state == DECODE) fsr_q <= (instruction_type == 2'b10);
      if (state == EXECALU || state == STOREEXEC) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    ma      = 1'b0;
    rd      = 1'b0;
    wd      = 1'b0;
    rw      = 1'b0;
    enram   = 1'b0;
    enrom   = 1'b0;
    fsr_sel = 1'b0;
    ir_load = 1'b0;
    alu_en  = 1'b0;
    pc_inc  = 1'b0;
    halted  = 1'b0;
    trap    = 1'b0;
    case (state)
      FETCH: begin
        enrom   = 1'b1;
        ir_load = (cnt == ROM_LAST);
      end
      READMEM: begin
        ma      = 1'b1;
        rd      = 1'b1;
        enram   = 1'b1;
        rw      = 1'b1;
        fsr_sel = fsr_q;
      end
      WRITEMEM: begin
        ma      = 1'b1;
        wd      = 1'b1;
        enram   = 1'b1;
        fsr_sel = fsr_q;
      end
      EXECALU: begin
        alu_en = 1'b1;
        pc_inc = 1'b1;
      end
      STOREEXEC: pc_inc = 1'b1;
      HALT:      halted = 1'b1;
      TRAP: begin
        trap   = 1'b1;
        pc_inc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// tb/tb_control_unit_mc.sv - randomized bench for control_unit_mc against a schedule-queue reference model
module tb_control_unit_mc;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_R = 3'd2, S_W = 3'd3;
  localparam logic [2:0] S_E = 3'd4, S_S = 3'd5, S_H = 3'd6, S_T = 3'd7;

  logic       clk = 1'b0;
  logic       rst, stall, resume;
  logic [1:0] itype;
  logic [2:0] icode;

  always #5 clk = ~clk;

  logic [2:0]  st0, st1;
  logic [11:0] out0, out1;
  logic [3:0]  ret0;
  logic [15:0] ret1;

  control_unit_mc #(.ROM_WAIT(0), .RAM_WAIT(0), .RET_W(4)) dut0 (
    .clk(clk), .rst(rst), .instruction_type(itype), .instruction_code(icode),
    .stall(stall), .resume(resume), .state(st0),
    .ma(out0[11]), .rd(out0[10]), .wd(out0[9]), .rw(out0[8]), .enram(out0[7]), .enrom(out0[6]),
    .fsr_sel(out0[5]), .ir_load(out0[4]), .alu_en(out0[3]), .pc_inc(out0[2]),
    .halted(out0[1]), .trap(out0[0]), .retired(ret0));

  control_unit_mc #(.ROM_WAIT(2), .RAM_WAIT(1), .RET_W(16)) dut1 (
    .clk(clk), .rst(rst), .instruction_type(itype), .instruction_code(icode),
    .stall(stall), .resume(resume), .state(st1),
    .ma(out1[11]), .rd(out1[10]), .wd(out1[9]), .rw(out1[8]), .enram(out1[7]), .enrom(out1[6]),
    .fsr_sel(out1[5]), .ir_load(out1[4]), .alu_en(out1[3]), .pc_inc(out1[2]),
    .halted(out1[1]), .trap(out1[0]), .retired(ret1));

  // model: each DUT gets a ring of upcoming {ir_load, state} entries, refilled per instruction
  int         rom_w [2] = '{0, 2};
  int         ram_w [2] = '{0, 1};
  logic [3:0] sched [2][64];
  int         head  [2];
  int         len   [2];
  int         ret_m [2];
  logic       fsr_m [2];
  int         errors = 0;
  int         checks = 0;

  task automatic push(input int k, input logic [3:0] e);
    sched[k][(head[k] + len[k]) % 64] = e;
    len[k]++;
  endtask

  task automatic push_fetch(input int k);
    for (int i = 0; i <= rom_w[k]; i++) push(k, {(i == rom_w[k]), S_F});
    push(k, {1'b0, S_D});
  endtask

  task automatic push_plan(input int k);
    case (itype)
      2'b00: push(k, {1'b0, S_E});
      2'b01, 2'b10: begin
        for (int i = 0; i <= ram_w[k]; i++) push(k, {1'b0, (icode == 3'b111) ? S_W : S_R});
        push(k, {1'b0, (icode == 3'b111) ? S_S : S_E});
      end
      default: push(k, {1'b0, (icode == 3'b000) ? S_H : S_T});
    endcase
  endtask

  task automatic model_step(input int k);
    logic [2:0] cur;
    cur = sched[k][head[k]][2:0];
    if (rst) begin
      head[k] = 0; len[k] = 0; ret_m[k] = 0; fsr_m[k] = 1'b0;
      push_fetch(k);
    end else if (!stall && !(cur == S_H && !resume)) begin
      head[k] = (head[k] + 1) % 64;
      len[k]--;
      if (cur == S_E || cur == S_S) ret_m[k]++;
      if (cur == S_D) begin
        fsr_m[k] = (itype == 2'b10);
        push_plan(k);
      end
      if (len[k] == 0) push_fetch(k);
    end
  endtask

  // expected {ma,rd,wd,rw,enram,enrom,fsr_sel,ir_load,alu_en,pc_inc,halted,trap}
  function automatic logic [11:0] exp_out(input logic [3:0] e, input logic fsr);
    case (e[2:0])
      S_F:     return {5'b00000, 1'b1, 1'b0, e[3], 4'b0000};
      S_R:     return {5'b11011, 1'b0, fsr, 5'b00000};
      S_W:     return {5'b10101, 1'b0, fsr, 5'b00000};
      S_E:     return 12'b0000_0000_1100;
      S_S:     return 12'b0000_0000_0100;
      S_H:     return 12'b0000_0000_0010;
      S_T:     return 12'b0000_0000_0101;
      default: return 12'b0;
    endcase
  endfunction

  task automatic check_all();
    logic [3:0] e0, e1;
    e0 = sched[0][head[0]];
    e1 = sched[1][head[1]];
    checks++;
    assert (st0 === e0[2:0]) else begin errors++; $error("FAIL state0 got=%b exp=%b t=%0t", st0, e0[2:0], $time); end
    checks++;
    assert (out0 === exp_out(e0, fsr_m[0])) else begin errors++; $error("FAIL outs0 got=%b exp=%b t=%0t", out0, exp_out(e0, fsr_m[0]), $time); end
    checks++;
    assert (ret0 === 4'(ret_m[0])) else begin errors++; $error("FAIL retired0 got=%0d exp=%0d t=%0t", ret0, 4'(ret_m[0]), $time); end
    checks++;
    assert (st1 === e1[2:0]) else begin errors++; $error("FAIL state1 got=%b exp=%b t=%0t", st1, e1[2:0], $time); end
    checks++;
    assert (out1 === exp_out(e1, fsr_m[1])) else begin errors++; $error("FAIL outs1 got=%b exp=%b t=%0t", out1, exp_out(e1, fsr_m[1]), $time); end
    checks++;
    assert (ret1 === 16'(ret_m[1])) else begin errors++; $error("FAIL retired1 got=%0d exp=%0d t=%0t", ret1, 16'(ret_m[1]), $time); end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  initial begin
    bit found;
    head = '{0, 0}; len = '{0, 0}; ret_m = '{0, 0}; fsr_m = '{1'b0, 1'b0};
    rst = 1'b1; stall = 1'b0; resume = 1'b0; itype = 2'b00; icode = 3'b000;
    tick();
    rst = 1'b0;
    // literal stream: dut0 wraps its 4-bit retired counter
    repeat (60) tick();

    repeat (700) begin
      itype  = 2'($urandom_range(0, 3));
      icode  = ($urandom_range(0, 2) == 0) ? ($urandom_range(0, 1) ? 3'b111 : 3'b000) : 3'($urandom_range(0, 7));
      stall  = ($urandom_range(0, 4) == 0);
      resume = ($urandom_range(0, 3) == 0);
      rst    = ($urandom_range(0, 199) == 0);
      tick();
    end

    rst = 1'b0; stall = 1'b0; resume = 1'b0; itype = 2'b11; icode = 3'b000;
    repeat (40) tick();
    resume = 1'b1;
    tick();
    resume = 1'b0; itype = 2'b01; icode = 3'b010;
    repeat (5) tick();
    stall = 1'b1;
    repeat (4) tick();
    stall = 1'b0;

    itype = 2'b10; icode = 3'b111;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (st0 == S_W) found = 1'b1;
    end
    checks++;
    assert (found) else begin errors++; $error("FAIL wait_writemem got=%b exp=1", found); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
